// File: rtl/moa_apx_sched.sv
// Multi-operand accumulator controller: folds operand pairs through approximate 4:2 compressors into a
// carry-save accumulator, then resolves the frame sum. Optional approximation-event counter: APX_ERR_CNT_EN.
module moa_apx_sched #(
   parameter int unsigned W     = 16,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_err_cnt,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_FILL_A   = 3'd0,
      S_FILL_B   = 3'd1,
      S_COMPRESS = 3'd2,
      S_RESOLVE  = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ACC_W-1:0]   acc_s_q, acc_s_d, acc_c_q, acc_c_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;
   logic               last_q, last_d, open_q, open_d, out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   sum_v;
   logic [ACC_W-2:0]   carry_v;
   logic               accept;

   assign in_ready  = (state_q == S_FILL_A) | (state_q == S_FILL_B);
   assign busy      = (state_q != S_FILL_A) | open_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign accept    = in_valid & in_ready;

   // Approximate 4:2 column: four ones give sum=1, carry=1 (one short of the exact 4).
   always_comb begin
      sum_v   = '0;
      carry_v = '0;
      for (int i = 0; i < ACC_W; i++) begin
         sum_v[i] = (acc_s_q[i] ^ acc_c_q[i] ^ a_q[i] ^ b_q[i]) |
                    (acc_s_q[i] & acc_c_q[i] & a_q[i] & b_q[i]);
      end
      for (int i = 0; i < ACC_W - 1; i++) begin
         carry_v[i] = (acc_s_q[i] & acc_c_q[i]) | (acc_s_q[i] & a_q[i]) | (acc_s_q[i] & b_q[i]) |
                      (acc_c_q[i] & a_q[i])     | (acc_c_q[i] & b_q[i]) | (a_q[i] & b_q[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      last_d      = last_q;
      open_d      = open_q;
      acc_s_d     = acc_s_q;
      acc_c_d     = acc_c_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_FILL_A: begin
            if (accept) begin
               a_d    = ACC_W'(in_data);
               open_d = 1'b1;
               if (in_last) begin
                  b_d     = '0;
                  last_d  = 1'b1;
                  state_d = S_COMPRESS;
               end else begin
                  state_d = S_FILL_B;
               end
            end
         end
         S_FILL_B: begin
            if (accept) begin
               b_d     = ACC_W'(in_data);
               last_d  = in_last;
               open_d  = 1'b1;
               state_d = S_COMPRESS;
            end
         end
         S_COMPRESS: begin
            acc_s_d = sum_v;
            acc_c_d = {carry_v, 1'b0};
            state_d = last_q ? S_RESOLVE : S_FILL_A;
         end
         S_RESOLVE: begin
            out_data_d  = acc_s_q + acc_c_q;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_s_d     = '0;
               acc_c_d     = '0;
               last_d      = 1'b0;
               open_d      = 1'b0;
               state_d     = S_FILL_A;
            end
         end
         default: state_d = S_FILL_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_FILL_A;
         a_q         <= '0;
         b_q         <= '0;
         last_q      <= 1'b0;
         open_q      <= 1'b0;
         acc_s_q     <= '0;
         acc_c_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         last_q      <= last_d;
         open_q      <= open_d;
         acc_s_q     <= acc_s_d;
         acc_c_q     <= acc_c_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef APX_ERR_CNT_EN
   localparam int unsigned ERR_W = $clog2(ACC_W + 1);
   localparam int unsigned SUM_W = ((CNT_W > ERR_W) ? CNT_W : ERR_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [ERR_W-1:0] err_pop;
   logic [SUM_W-1:0] cnt_sum;
   logic [CNT_W-1:0] cnt_q, cnt_d, out_err_q, out_err_d;

   assign out_err_cnt = out_err_q;

   // Count columns where all four inputs are set in this compress step.
   always_comb begin
      err_pop = '0;
      for (int i = 0; i < ACC_W; i++) begin
         err_pop = err_pop + ERR_W'(acc_s_q[i] & acc_c_q[i] & a_q[i] & b_q[i]);
      end
   end

   always_comb begin
      cnt_sum   = SUM_W'(cnt_q) + SUM_W'(err_pop);
      cnt_d     = cnt_q;
      out_err_d = out_err_q;
      case (state_q)
         S_COMPRESS: cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);
         S_RESOLVE:  out_err_d = cnt_q;
         S_DONE: begin
            if (out_ready) begin
               cnt_d     = '0;
               out_err_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         out_err_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         out_err_q <= out_err_d;
      end
   end
`else
   assign out_err_cnt = '0;
`endif

endmodule

// File: tb/tb_moa_apx_sched.sv
// Directed bench for moa_apx_sched: table of frames plus latency, backpressure and mid-frame reset sequences.
module tb_moa_apx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic [7:0]  out_err_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   moa_apx_sched #(.W(16), .ACC_W(24), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err_cnt(out_err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef APX_ERR_CNT_EN
   localparam logic [7:0] ERR_SIX_FFFF = 8'd15;
`else
   localparam logic [7:0] ERR_SIX_FFFF = 8'd0;
`endif

   typedef struct {
      string       name;
      int          n;
      logic [15:0] ops [6];
      logic        chk_acc;
      logic [23:0] exp_s;
      logic [23:0] exp_c;
      logic [23:0] exp_data;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one operand; returns how many sample points it took before acceptance.
   task automatic send(input logic [15:0] d, input logic l, output int tries);
      logic got;
      got   = 1'b0;
      tries = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int k = 0; k < 20 && !got; k++) begin
         got = in_ready;
         tries++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
      end
   endtask

   // Run a full frame; the caller is #1 after an edge with out_ready=1.
   task automatic run_frame(input vec_t v);
      int t;
      for (int i = 0; i < v.n; i++) begin
         send(v.ops[i], (i == v.n - 1), t);
         if (i == 0) check({v.name, "_busy"}, 32'(busy), 32'd1);
      end
      check({v.name, "_valid_t1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      if (v.chk_acc) begin
         check({v.name, "_acc_s"}, 32'(dut.acc_s_q), 32'(v.exp_s));
         check({v.name, "_acc_c"}, 32'(dut.acc_c_q), 32'(v.exp_c));
      end
      check({v.name, "_valid_t2"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check({v.name, "_valid_t3"}, 32'(out_valid), 32'd1);
      check({v.name, "_data"}, 32'(out_data), 32'(v.exp_data));
      check({v.name, "_err"}, 32'(out_err_cnt), 32'(v.exp_err));
      @(posedge clk); #1;
      check({v.name, "_valid_after"}, 32'(out_valid), 32'd0);
      check({v.name, "_ready_after"}, 32'(in_ready), 32'd1);
      check({v.name, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int   t;
      vec_t v;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      vecs[0] = '{"f1234",  4, '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0}, 1'b1, 24'd4, 24'd6,  24'd10, 8'd0};
      vecs[1] = '{"f7911",  3, '{16'd7, 16'd9, 16'd11, 16'd0, 16'd0, 16'd0}, 1'b1, 24'd7, 24'd20, 24'd27, 8'd0};
      vecs[2] = '{"f6ffff", 6, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                  1'b1, 24'h00FFFE, 24'h03FFFE, 24'h04FFFC, ERR_SIX_FFFF};
      vecs[3] = '{"f5",     1, '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b1, 24'd5, 24'd0, 24'd5, 8'd0};
      vecs[4] = '{"f100200",2, '{16'd100, 16'd200, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b0, 24'd0, 24'd0, 24'd300, 8'd0};
      vecs[5] = '{"fwrap",  2, '{16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b0, 24'd0, 24'd0, 24'h010000, 8'd0};

      @(posedge clk); @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_err", 32'(out_err_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         run_frame(v);
      end

      // Backpressure: result holds, then next operand is accepted the cycle after the handshake.
      out_ready = 1'b0;
      send(16'd5, 1'b1, t);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_data", 32'(out_data), 32'd5);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(16'd9, 1'b1, t);
      check("bp_next_accept_tries", 32'(t), 32'd2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_data", 32'(out_data), 32'd9);
      @(posedge clk); #1;

      // Mid-frame reset drops the partial frame.
      send(16'd1, 1'b0, t);
      send(16'd2, 1'b0, t);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mr_in_ready", 32'(in_ready), 32'd1);
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_out_data", 32'(out_data), 32'd0);
      check("mr_err", 32'(out_err_cnt), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_acc_s", 32'(dut.acc_s_q), 32'd0);
      check("mr_acc_c", 32'(dut.acc_c_q), 32'd0);
      v = vecs[3];
      v.name = "mr_f5";
      run_frame(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
